i2s_row_streamer: RTL and testbench



---
 rtl/i2s_led_pkg.sv | 38 +++
 rtl/i2s_shift_out.sv | 50 +++++
 rtl/i2s_row_streamer.sv | 152 +++++++++++++++
 tb/tb_i2s_row_streamer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/i2s_led_pkg.sv
// Shared definitions for the I2S LED row stream (streamer and i2s_mask).
// Header layout: {nx[3:0], ny[3:0], 2'b00, row[5:0]}, sent MSB first.
package i2s_led_pkg;

    localparam int HDR_BITS  = 16;
    localparam int WORD_BITS = 16;

    localparam int NX_MSB  = 15;
    localparam int NX_LSB  = 12;
    localparam int NY_MSB  = 11;
    localparam int NY_LSB  = 8;
    localparam int ROW_MSB = 5;
    localparam int ROW_LSB = 0;

    typedef enum logic [1:0] {
        HDR  = 2'd0,
        DATA = 2'd1,
        PAD  = 2'd2
    } stream_state_t;

    function automatic logic [HDR_BITS-1:0] make_header(input logic [3:0] nx,
                                                        input logic [3:0] ny,
                                                        input logic [5:0] row);
        logic [HDR_BITS-1:0] h;
        h                  = '0;
        h[NX_MSB:NX_LSB]   = nx;
        h[NY_MSB:NY_LSB]   = ny;
        h[ROW_MSB:ROW_LSB] = row;
        return h;
    endfunction

    // Words per row; 9 bits so the 16x16 module case (256) does not wrap.
    function automatic logic [8:0] frame_words(input logic [3:0] nx,
                                               input logic [3:0] ny);
        return ({5'd0, nx} + 9'd1) * ({5'd0, ny} + 9'd1);
    endfunction

endpackage

// File: rtl/i2s_shift_out.sv
// 16-bit load/shift register with a bit counter; loads itself whenever the
// next bit to drive is bit 15, so one instance serves headers and data words.
module i2s_shift_out
    import i2s_led_pkg::*;
(
    input  logic                 i2s_clk,
    input  logic                 rst_n,
    input  logic                 advance,
    input  logic [WORD_BITS-1:0] load_val,
    output logic                 bit_out,
    output logic [3:0]           bit_idx,
    output logic                 last_bit
);

    localparam logic [3:0] TOP_BIT = 4'(WORD_BITS - 1);

    logic [WORD_BITS-1:0] sr_q, sr_d;
    logic [3:0]           idx_q, idx_d;

    // The first bit of a word comes straight from load_val, not from sr_q.
    assign bit_out  = (idx_q == TOP_BIT) ? load_val[WORD_BITS-1] : sr_q[WORD_BITS-1];
    assign bit_idx  = idx_q;
    assign last_bit = (idx_q == 4'd0);

    always_comb begin
        sr_d  = sr_q;
        idx_d = idx_q;
        if (advance) begin
            if (idx_q == TOP_BIT) begin
                sr_d = {load_val[WORD_BITS-2:0], 1'b0};
            end else begin
                sr_d = {sr_q[WORD_BITS-2:0], 1'b0};
            end
            idx_d = idx_q - 4'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; next-state
    // logic lives in always_comb so each flop has exactly one driver.
    always_ff @(negedge i2s_clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q  <= '0;
            idx_q <= TOP_BIT;
        end else begin
            sr_q  <= sr_d;
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/i2s_row_streamer.sv
// Endless row scanner: per frame sends header, W pixel words, one pad bit,
// all on the falling edge so the masks sample mid-bit on the rising edge.
module i2s_row_streamer
    import i2s_led_pkg::*;
#(
    parameter int ROWS   = 16,
    parameter int ADDR_W = 14
) (
    input  logic              i2s_clk,
    input  logic              rst_n,
    input  logic [3:0]        num_modules_x,
    input  logic [3:0]        num_modules_y,
    input  logic              hold,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [15:0]       rd_data,
    output logic              i2s_data,
    output logic              frame_start,
    output logic              scan_done
);

    localparam logic [5:0] LAST_ROW = 6'(ROWS - 1);

    stream_state_t     state_q, state_d;
    logic [5:0]        row_q, row_d;
    logic [7:0]        word_q, word_d;
    logic [3:0]        nx_q, nx_d, ny_q, ny_d;
    logic              i2s_data_q, i2s_data_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              frame_start_q, frame_start_d;
    logic              scan_done_q, scan_done_d;

    logic                 advance;
    logic [WORD_BITS-1:0] load_val;
    logic                 bit_out;
    logic [3:0]           bit_idx;
    logic                 last_bit;
    logic [8:0]           words;
    logic [8:0]           next_word;

    i2s_shift_out u_shift (
        .i2s_clk  (i2s_clk),
        .rst_n    (rst_n),
        .advance  (advance),
        .load_val (load_val),
        .bit_out  (bit_out),
        .bit_idx  (bit_idx),
        .last_bit (last_bit)
    );

    assign words     = frame_words(nx_q, ny_q);
    assign next_word = {1'b0, word_q} + 9'd1;

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        word_d        = word_q;
        nx_d          = nx_q;
        ny_d          = ny_q;
        rd_addr_d     = rd_addr_q;
        i2s_data_d    = 1'b0;
        rd_en_d       = 1'b0;
        frame_start_d = 1'b0;
        scan_done_d   = 1'b0;
        advance       = 1'b0;
        load_val      = rd_data;

        case (state_q)
            HDR: begin
                advance    = 1'b1;
                load_val   = make_header(num_modules_x, num_modules_y, row_q);
                i2s_data_d = bit_out;
                if (bit_idx == 4'd15) begin
                    frame_start_d = 1'b1;
                    nx_d          = num_modules_x;
                    ny_d          = num_modules_y;
                end
                if (bit_idx == 4'd1) begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = ADDR_W'({row_q, 8'd0});
                end
                if (last_bit) begin
                    state_d = DATA;
                    word_d  = 8'd0;
                end
            end
            DATA: begin
                advance    = 1'b1;
                i2s_data_d = bit_out;
                // Prefetch the following word two edges before it is needed.
                if (bit_idx == 4'd1 && next_word < words) begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = ADDR_W'({row_q, next_word[7:0]});
                end
                if (last_bit) begin
                    if (next_word == words) begin
                        state_d = PAD;
                    end else begin
                        word_d = next_word[7:0];
                    end
                end
            end
            PAD: begin
                state_d = HDR;
                if (!hold) begin
                    if (row_q == LAST_ROW) begin
                        row_d       = 6'd0;
                        scan_done_d = 1'b1;
                    end else begin
                        row_d = row_q + 6'd1;
                    end
                end
            end
            default: state_d = HDR;
        endcase
    end

    always_ff @(negedge i2s_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= HDR;
            row_q         <= 6'd0;
            word_q        <= 8'd0;
            nx_q          <= 4'd0;
            ny_q          <= 4'd0;
            i2s_data_q    <= 1'b0;
            rd_en_q       <= 1'b0;
            rd_addr_q     <= '0;
            frame_start_q <= 1'b0;
            scan_done_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            word_q        <= word_d;
            nx_q          <= nx_d;
            ny_q          <= ny_d;
            i2s_data_q    <= i2s_data_d;
            rd_en_q       <= rd_en_d;
            rd_addr_q     <= rd_addr_d;
            frame_start_q <= frame_start_d;
            scan_done_q   <= scan_done_d;
        end
    end

    assign i2s_data    = i2s_data_q;
    assign rd_en       = rd_en_q;
    assign rd_addr     = rd_addr_q;
    assign frame_start = frame_start_q;
    assign scan_done   = scan_done_q;

endmodule

// File: tb/tb_i2s_row_streamer.sv
// Scoreboard bench: each frame's expected per-edge outputs are queued when the
// frame's stimulus is set up, then popped and compared on every rising edge.
module tb_i2s_row_streamer;

    localparam int ROWS = 3;

    logic        i2s_clk;
    logic        rst_n;
    logic [3:0]  num_modules_x;
    logic [3:0]  num_modules_y;
    logic        hold;
    logic        rd_en;
    logic [13:0] rd_addr;
    logic [15:0] rd_data;
    logic        i2s_data;
    logic        frame_start;
    logic        scan_done;

    typedef struct {
        logic        d;
        logic        fs;
        logic        sd;
        logic        re;
        logic [13:0] addr;
        int          fr;
        int          e;
    } rec_t;

    rec_t        exp_q[$];
    logic [15:0] mem [0:16383];
    int          n_total = 0;
    int          n_bad   = 0;
    int          model_row = 0;
    int          frame_no  = 0;

    i2s_row_streamer #(.ROWS(ROWS), .ADDR_W(14)) dut (
        .i2s_clk       (i2s_clk),
        .rst_n         (rst_n),
        .num_modules_x (num_modules_x),
        .num_modules_y (num_modules_y),
        .hold          (hold),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .i2s_data      (i2s_data),
        .frame_start   (frame_start),
        .scan_done     (scan_done)
    );

    initial begin
        i2s_clk = 1'b1;
        forever #5 i2s_clk = ~i2s_clk;
    end

    // Synchronous pixel buffer: data valid on the falling edge after rd_en.
    always @(negedge i2s_clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge i2s_clk) begin : scoreboard
        rec_t r;
        if (exp_q.size() != 0) begin
            r = exp_q.pop_front();
            check($sformatf("f%0d.e%0d data", r.fr, r.e), 32'(i2s_data), 32'(r.d));
            check($sformatf("f%0d.e%0d frame_start", r.fr, r.e), 32'(frame_start), 32'(r.fs));
            check($sformatf("f%0d.e%0d scan_done", r.fr, r.e), 32'(scan_done), 32'(r.sd));
            check($sformatf("f%0d.e%0d rd_en", r.fr, r.e), 32'(rd_en), 32'(r.re));
            if (r.re) check($sformatf("f%0d.e%0d rd_addr", r.fr, r.e), 32'(rd_addr), 32'(r.addr));
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, " i2s_data"}, 32'(i2s_data), 32'd0);
        check({tag, " rd_en"}, 32'(rd_en), 32'd0);
        check({tag, " rd_addr"}, 32'(rd_addr), 32'd0);
        check({tag, " frame_start"}, 32'(frame_start), 32'd0);
        check({tag, " scan_done"}, 32'(scan_done), 32'd0);
    endtask

    // Reset is asserted and released while i2s_clk is high.
    task automatic apply_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check_reset_outputs({tag, " asserted"});
        repeat (3) @(posedge i2s_clk);
        #1;
        check_reset_outputs({tag, " held"});
        rst_n     = 1'b1;
        model_row = 0;
    endtask

    // Called 1 time unit after a rising edge, before the frame's first edge.
    task automatic do_frame(input logic [3:0] nx, input logic [3:0] ny, input logic h,
                            input int new_nx, input int abort_at);
        int          w;
        int          len;
        int          n_edges;
        logic [15:0] hdr;
        logic [15:0] v;
        rec_t        r;
        num_modules_x = nx;
        num_modules_y = ny;
        hold          = h;
        w   = (int'(nx) + 1) * (int'(ny) + 1);
        len = 17 + 16 * w;
        n_edges = (abort_at >= 0) ? abort_at + 1 : len;
        hdr = {nx, ny, 2'b00, 6'(model_row)};
        for (int j = 0; j < n_edges; j++) begin
            r.d = 1'b0; r.fs = 1'b0; r.sd = 1'b0; r.re = 1'b0; r.addr = '0;
            r.fr = frame_no; r.e = j;
            if (j < 16) begin
                r.d  = hdr[15 - j];
                r.fs = (j == 0);
                if (j == 14) begin
                    r.re   = 1'b1;
                    r.addr = {6'(model_row), 8'd0};
                end
            end else if (j < len - 1) begin
                int k;
                int b;
                k = (j - 16) / 16;
                b = 15 - ((j - 16) % 16);
                v = mem[{6'(model_row), 8'(k)}];
                r.d = v[b];
                if (b == 1 && k + 1 < w) begin
                    r.re   = 1'b1;
                    r.addr = {6'(model_row), 8'(k + 1)};
                end
            end else begin
                r.sd = !h && (model_row == ROWS - 1);
            end
            exp_q.push_back(r);
        end
        for (int j = 0; j < n_edges; j++) begin
            @(posedge i2s_clk);
            #1;
            if (new_nx >= 0 && j == 30) num_modules_x = 4'(new_nx);
        end
        frame_no++;
        if (abort_at < 0 && !h) model_row = (model_row == ROWS - 1) ? 0 : model_row + 1;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n         = 1'b0;
        num_modules_x = 4'd0;
        num_modules_y = 4'd0;
        hold          = 1'b0;
        for (int i = 0; i < 16384; i++) mem[i] = 16'($urandom);
        mem[{6'd0, 8'd0}] = 16'hA5C3;
        mem[{6'd1, 8'd0}] = 16'h0F0F;
        mem[{6'd2, 8'd2}] = 16'hFFFF;

        apply_reset("por");
        do_frame(4'd0, 4'd0, 1'b0, -1, -1);   // row 0: 0000, A5C3, 0
        do_frame(4'd0, 4'd0, 1'b0, -1, -1);   // row 1: 0001, 0F0F, 0
        do_frame(4'd0, 4'd0, 1'b0, -1, -1);   // row 2: scan_done
        do_frame(4'd1, 4'd1, 1'b0, -1, -1);   // row 0, W=4
        do_frame(4'd1, 4'd1, 1'b1, -1, -1);   // row 1 held
        do_frame(4'd1, 4'd1, 1'b0, -1, -1);   // row 1 repeated
        do_frame(4'd0, 4'd0, 1'b0, 2, -1);    // row 2, nx changes mid-DATA
        do_frame(4'd2, 4'd0, 1'b0, -1, -1);   // row 0, W=3
        do_frame(4'd3, 4'd2, 1'b0, -1, -1);   // row 1, W=12
        do_frame(4'd1, 4'd1, 1'b0, -1, 56);   // row 2, cut at bit 7 of word 2
        apply_reset("mid_frame");
        do_frame(4'd0, 4'd1, 1'b0, -1, -1);   // row 0 after reset, W=2
        do_frame(4'd15, 4'd15, 1'b0, -1, -1); // row 1, W=256
        do_frame(4'd0, 4'd0, 1'b0, -1, -1);   // row 2: scan_done
        @(posedge i2s_clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
